// File: rtl/ant_pkg.sv
// Shared types for the unified-memory arbiter.
//   mem_arb_state_t : arbiter FSM encoding (IDLE, ISSUE, WAIT, DONE), 2 bits
//   arb_port_t      : requester identity (PORT_IF = fetch, PORT_D = load/store)
package ant_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } arb_port_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker.
//   req  : request vector, bit 0 = fetch, bit 1 = load/store
//   last : port granted most recently
//   gnt  : winning port (only meaningful when any = 1)
//   any  : at least one request is pending
module rr_arb2
    import ant_pkg::*;
(
    input  logic [1:0] req,
    input  arb_port_t  last,
    output arb_port_t  gnt,
    output logic       any
);

    // Pick the single requester, or on a tie the port that did not win last.
    always_comb begin
        gnt = PORT_IF;
        any = req[0] | req[1];
        case (req)
            2'b01:   gnt = PORT_IF;
            2'b10:   gnt = PORT_D;
            2'b11:   gnt = (last == PORT_D) ? PORT_IF : PORT_D;
            default: gnt = PORT_IF;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch port and the load/store port. Accesses are serialised by
// a four-state FSM; each access returns a one-cycle done pulse to its port.
//   clock/reset           : clock, synchronous active-low reset
//   if_req/if_addr        : fetch request and address; if_done pulse
//   d_req/d_we/d_addr/... : load/store request; d_done pulse
//   rdata                 : registered read data shared by both ports
//   if_stall/d_stall      : request pending and not yet done
//   mem_*                 : memory macro interface (read data one cycle later)
module mem_arbiter
    import ant_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              if_stall,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    mem_arb_state_t    state_q, state_d;
    arb_port_t         gnt_q, gnt_d;
    arb_port_t         last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    arb_port_t         pick_s;
    logic              any_s;

    rr_arb2 u_rr_arb2 (
        .req  ({d_req, if_req}),
        .last (last_q),
        .gnt  (pick_s),
        .any  (any_s)
    );

    // Next-state logic: requests are only looked at in IDLE; everything after
    // that works from the latched copy so mid-access input changes are ignored.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d = ISSUE;
                    gnt_d   = pick_s;
                    if (pick_s == PORT_D) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Memory data is valid here, one cycle after the read strobe.
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end else begin
                    rdata_d = rdata_q;
                end
                state_d = DONE;
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; reset aborts any in-flight access silently.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= PORT_IF;
            last_q  <= PORT_D;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = (state_q == ISSUE) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_done   = (state_q == DONE) & (gnt_q == PORT_IF);
    assign d_done    = (state_q == DONE) & (gnt_q == PORT_D);
    assign rdata     = rdata_q;
    assign if_stall  = if_req & ~if_done;
    assign d_stall   = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] rdata;
    logic        if_stall;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] mem [256];
    logic        load_mem;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          if_done_cnt = 0;
    int          d_done_cnt  = 0;
    int          we_cnt      = 0;
    int          base_a;
    int          base_b;

    mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .rdata     (rdata),
        .if_stall  (if_stall),
        .d_stall   (d_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] init_word(input logic [7:0] a);
        if (a == 8'h10) return 16'hBEEF;
        else            return {~a, a};
    endfunction

    // Synchronous single-port memory model: read data one cycle after mem_en.
    always @(posedge clock) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Event counters sampled away from the active edge.
    always @(negedge clock) begin
        if (if_done) if_done_cnt <= if_done_cnt + 1;
        if (d_done)  d_done_cnt  <= d_done_cnt + 1;
        if (mem_en && mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; load_mem = 1'b1;
        if_req = 1'b0; if_addr = 8'h00;
        d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 16'h0000;
        repeat (3) nx();
        reset = 1'b1; load_mem = 1'b0;
        check("rst_rdata",  32'(rdata),   32'h0);
        check("rst_mem_en", 32'(mem_en),  32'h0);
        check("rst_mem_we", 32'(mem_we),  32'h0);
        check("rst_ifdone", 32'(if_done), 32'h0);
        check("rst_ddone",  32'(d_done),  32'h0);

        // Fetch only
        nx();
        if_req = 1'b1; if_addr = 8'h10; #1;
        check("f_if_stall_rise", 32'(if_stall), 32'h1);
        check("f_d_stall_idle",  32'(d_stall),  32'h0);
        nx();
        check("f_issue_en",   32'(mem_en),   32'h1);
        check("f_issue_we",   32'(mem_we),   32'h0);
        check("f_issue_addr", 32'(mem_addr), 32'h10);
        check("f_issue_done", 32'(if_done),  32'h0);
        nx();
        check("f_wait_en",   32'(mem_en),  32'h0);
        check("f_wait_done", 32'(if_done), 32'h0);
        check("f_wait_stall", 32'(if_stall), 32'h1);
        nx();
        check("f_done",       32'(if_done),  32'h1);
        check("f_done_d",     32'(d_done),   32'h0);
        check("f_rdata",      32'(rdata),    32'hBEEF);
        check("f_stall_done", 32'(if_stall), 32'h0);
        if_req = 1'b0; if_addr = 8'h00;
        nx();
        check("f_after_done", 32'(if_done), 32'h0);
        check("f_after_en",   32'(mem_en),  32'h0);
        check("f_no_d_done",  32'(d_done_cnt), 32'h0);

        // Store then load
        base_a = we_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'h1234; #1;
        check("s_d_stall_rise", 32'(d_stall), 32'h1);
        nx();
        check("s_issue_en",    32'(mem_en),    32'h1);
        check("s_issue_we",    32'(mem_we),    32'h1);
        check("s_issue_addr",  32'(mem_addr),  32'h20);
        check("s_issue_wdata", 32'(mem_wdata), 32'h1234);
        nx();
        nx();
        check("s_done",        32'(d_done),  32'h1);
        check("s_rdata_keep",  32'(rdata),   32'hBEEF);
        check("s_stall_done",  32'(d_stall), 32'h0);
        d_we = 1'b0;
        nx();
        check("l_idle_done",  32'(d_done),  32'h0);
        check("l_idle_stall", 32'(d_stall), 32'h1);
        nx();
        check("l_issue_en",   32'(mem_en),   32'h1);
        check("l_issue_we",   32'(mem_we),   32'h0);
        check("l_issue_addr", 32'(mem_addr), 32'h20);
        nx();
        nx();
        check("l_done",  32'(d_done), 32'h1);
        check("l_rdata", 32'(rdata),  32'h1234);
        d_req = 1'b0;
        nx();
        check("s_one_write",  32'(we_cnt - base_a), 32'h1);
        check("l_stall_idle", 32'(d_stall), 32'h0);

        // Simultaneous requests out of reset
        reset = 1'b0;
        nx();
        reset = 1'b1;
        check("r2_rdata", 32'(rdata), 32'h0);
        if_req = 1'b1; if_addr = 8'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h06;
        for (int k = 1; k <= 16; k++) begin
            nx();
            check($sformatf("both_if_%0d", k), 32'(if_done), 32'((k == 3) || (k == 11)));
            check($sformatf("both_d_%0d", k),  32'(d_done),  32'((k == 7) || (k == 15)));
            if (k == 3) check("both_rdata_if", 32'(rdata), 32'hBEEF);
            if (k == 7) check("both_rdata_d",  32'(rdata), 32'hF906);
            if (k == 15) begin
                if_req = 1'b0; d_req = 1'b0;
            end
        end

        // Mid-access input change
        if_req = 1'b1; if_addr = 8'h05;
        nx();
        check("m_issue_addr", 32'(mem_addr), 32'h05);
        nx();
        if_addr = 8'h06;
        nx();
        check("m_done",  32'(if_done), 32'h1);
        check("m_rdata", 32'(rdata),   32'hFA05);
        if_req = 1'b0;
        nx();

        // Reset mid-access
        base_b = if_done_cnt;
        if_req = 1'b1; if_addr = 8'h10;
        nx();
        check("x_issue_en", 32'(mem_en), 32'h1);
        nx();
        reset = 1'b0; if_req = 1'b0;
        nx();
        check("x_no_done", 32'(if_done), 32'h0);
        check("x_rdata",   32'(rdata),   32'h0);
        check("x_en",      32'(mem_en),  32'h0);
        reset = 1'b1;
        nx();
        check("x_idle_en",   32'(mem_en),  32'h0);
        check("x_idle_done", 32'(if_done), 32'h0);
        if_req = 1'b1; if_addr = 8'h10;
        nx();
        check("x_new_issue", 32'(mem_en), 32'h1);
        nx();
        nx();
        check("x_new_done",  32'(if_done), 32'h1);
        check("x_new_rdata", 32'(rdata),   32'hBEEF);
        if_req = 1'b0;
        nx();
        check("x_done_count", 32'(if_done_cnt - base_b), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
